dual_bank_sched: RTL and testbench

- Parametrised successor to the two-port control unit (Control_unit_CU_2).
- Accepts pairs of memory addresses (port A, port B) over a valid/ready handshake and sequences the two MAR_2 loads and the MEM_2 port enables for each pair.
- Detects bank conflicts across N_BANKS interleaved banks and serialises conflicting pairs with an overlapped A/B schedule.
- Keeps built-in cycle, pair and dual-issue counters, so benches read metrics from the block rather than computing them.

---
 rtl/dual_bank_sched_pkg.sv | 22 ++
 rtl/sat_counter.sv | 33 +++
 rtl/dual_bank_sched.sv | 148 ++++++++++++++
 tb/tb_dual_bank_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dual_bank_sched_pkg.sv
// Shared types and helpers for the dual-bank request scheduler.
package dual_bank_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD_AB    = 3'd1,
    S_ACC_AB     = 3'd2,
    S_LOAD_A     = 3'd3,
    S_ACC_A_LD_B = 3'd4,
    S_ACC_B      = 3'd5
  } state_e;

  // Bank index width, at least one bit even for a single bank.
  function automatic int unsigned bank_w_of(input int unsigned n_banks);
    return (n_banks <= 1) ? 1 : $clog2(n_banks);
  endfunction

  function automatic logic [2:0] bank_of(input logic [2:0] addr, input int unsigned n_banks);
    return addr & 3'(n_banks - 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dual_bank_sched.sv
// Sequences MAR loads and MEM port enables for A/B address pairs, serialising bank conflicts.
module dual_bank_sched
  import dual_bank_sched_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned N_BANKS = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic              req_we,
  output logic              stall,
  output logic              mar_load_a,
  output logic [ADDR_W-1:0] mar_in_a,
  output logic              mar_load_b,
  output logic [ADDR_W-1:0] mar_in_b,
  output logic              mem_oe_a,
  output logic              mem_ld_a,
  output logic              mem_oe_b,
  output logic              mem_ld_b,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  cnt_cycles,
  output logic [CNT_W-1:0]  cnt_pairs,
  output logic [CNT_W-1:0]  cnt_dual
);

  localparam int unsigned BankW = bank_w_of(N_BANKS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] la_q, la_d, lb_q, lb_d;
  logic              lwe_q, lwe_d;
  logic [BankW-1:0]  bank_a, bank_b;
  logic              accept, conflict;

  // Conflict is judged on the incoming pair so the accept edge can pick the schedule.
  assign bank_a   = BankW'(bank_of(3'(req_addr_a), N_BANKS));
  assign bank_b   = BankW'(bank_of(3'(req_addr_b), N_BANKS));
  assign conflict = (bank_a == bank_b) && !((req_addr_a == req_addr_b) && !req_we);
  assign accept   = req_valid && req_ready;

  always_comb begin
    req_ready  = 1'b0;
    mar_load_a = 1'b0;
    mar_load_b = 1'b0;
    mem_oe_a   = 1'b0;
    mem_ld_a   = 1'b0;
    mem_oe_b   = 1'b0;
    mem_ld_b   = 1'b0;
    unique case (state_q)
      S_IDLE:    req_ready = 1'b1;
      S_LOAD_AB: begin
        mar_load_a = 1'b1;
        mar_load_b = 1'b1;
      end
      S_ACC_AB: begin
        mem_oe_a  = ~lwe_q;
        mem_ld_a  = lwe_q;
        mem_oe_b  = ~lwe_q;
        mem_ld_b  = lwe_q;
        req_ready = 1'b1;
      end
      S_LOAD_A:  mar_load_a = 1'b1;
      S_ACC_A_LD_B: begin
        mem_oe_a   = ~lwe_q;
        mem_ld_a   = lwe_q;
        mar_load_b = 1'b1;
      end
      S_ACC_B: begin
        mem_oe_b  = ~lwe_q;
        mem_ld_b  = lwe_q;
        req_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall    = ~req_ready;
  assign mar_in_a = la_q;
  assign mar_in_b = lb_q;

  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    lb_d    = lb_q;
    lwe_d   = lwe_q;
    if (accept) begin
      la_d  = req_addr_a;
      lb_d  = req_addr_b;
      lwe_d = req_we;
    end
    unique case (state_q)
      S_IDLE, S_ACC_AB, S_ACC_B: begin
        if (accept) begin
          state_d = conflict ? S_LOAD_A : S_LOAD_AB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_AB:    state_d = S_ACC_AB;
      S_LOAD_A:     state_d = S_ACC_A_LD_B;
      S_ACC_A_LD_B: state_d = S_ACC_B;
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      la_q    <= '0;
      lb_q    <= '0;
      lwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      lwe_q   <= lwe_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt_cycles (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clear),
    .inc(1'b1),
    .q  (cnt_cycles)
  );

  sat_counter #(.W(CNT_W)) u_cnt_pairs (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clear),
    .inc(accept),
    .q  (cnt_pairs)
  );

  sat_counter #(.W(CNT_W)) u_cnt_dual (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clear),
    .inc(mem_oe_a && mem_oe_b),
    .q  (cnt_dual)
  );

endmodule

// File: tb/tb_dual_bank_sched.sv
// Directed bench for dual_bank_sched with hand-computed strobe and counter expectations.
module tb_dual_bank_sched;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr_a;
  logic [3:0]  req_addr_b;
  logic        req_we;
  logic        stall;
  logic        mar_load_a;
  logic [3:0]  mar_in_a;
  logic        mar_load_b;
  logic [3:0]  mar_in_b;
  logic        mem_oe_a;
  logic        mem_ld_a;
  logic        mem_oe_b;
  logic        mem_ld_b;
  logic        cnt_clear;
  logic [15:0] cnt_cycles;
  logic [15:0] cnt_pairs;
  logic [15:0] cnt_dual;

  int errors = 0;
  int checks = 0;

  // Strobe vector order: {mla, mlb, oea, lda, oeb, ldb, ready}
  localparam logic [6:0] StIdle    = 7'b0000001;
  localparam logic [6:0] StLoadAb  = 7'b1100000;
  localparam logic [6:0] StAccAbR  = 7'b0010101;
  localparam logic [6:0] StLoadA   = 7'b1000000;
  localparam logic [6:0] StAccALdR = 7'b0110000;
  localparam logic [6:0] StAccALdW = 7'b0101000;
  localparam logic [6:0] StAccBR   = 7'b0000101;
  localparam logic [6:0] StAccBW   = 7'b0000011;

  dual_bank_sched #(
    .ADDR_W (4),
    .N_BANKS(2),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr_a(req_addr_a),
    .req_addr_b(req_addr_b),
    .req_we    (req_we),
    .stall     (stall),
    .mar_load_a(mar_load_a),
    .mar_in_a  (mar_in_a),
    .mar_load_b(mar_load_b),
    .mar_in_b  (mar_in_b),
    .mem_oe_a  (mem_oe_a),
    .mem_ld_a  (mem_ld_a),
    .mem_oe_b  (mem_oe_b),
    .mem_ld_b  (mem_ld_b),
    .cnt_clear (cnt_clear),
    .cnt_cycles(cnt_cycles),
    .cnt_pairs (cnt_pairs),
    .cnt_dual  (cnt_dual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] strb();
    return {mar_load_a, mar_load_b, mem_oe_a, mem_ld_a, mem_oe_b, mem_ld_b, req_ready};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
  endtask

  task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic we);
    req_valid  = 1'b1;
    req_addr_a = a;
    req_addr_b = b;
    req_we     = we;
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr_a = '0;
    req_addr_b = '0;
    req_we     = 1'b0;
    cnt_clear  = 1'b0;
    step();
    step();
    check("reset_strobes", 32'(strb()), 32'(StIdle));
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_counters", {cnt_cycles, cnt_pairs}, 32'd0);
    check("reset_dual", 32'(cnt_dual), 32'd0);
    rst = 1'b1;
    step();
    check("cycles_after_release", 32'(cnt_cycles), 32'd1);

    // Non-conflicting read pair: banks 0 and 1.
    clear_counters();
    offer(4'h2, 4'h5, 1'b0);
    step();
    req_valid = 1'b0;
    check("dual_load", 32'(strb()), 32'(StLoadAb));
    check("dual_mar", 32'({mar_in_a, mar_in_b}), 32'h25);
    check("dual_stall", 32'(stall), 32'd1);
    step();
    check("dual_access", 32'(strb()), 32'(StAccAbR));
    step();
    check("dual_idle", 32'(strb()), 32'(StIdle));
    check("dual_cnt_dual", 32'(cnt_dual), 32'd1);
    check("dual_cnt_pairs", 32'(cnt_pairs), 32'd1);
    check("dual_cnt_cycles", 32'(cnt_cycles), 32'd3);

    // Conflicting read pair: both bank 0.
    clear_counters();
    offer(4'h2, 4'h4, 1'b0);
    step();
    req_valid = 1'b0;
    check("conf_load_a", 32'(strb()), 32'(StLoadA));
    check("conf_stall1", 32'(stall), 32'd1);
    step();
    check("conf_acc_a_ld_b", 32'(strb()), 32'(StAccALdR));
    check("conf_stall2", 32'(stall), 32'd1);
    step();
    check("conf_acc_b", 32'(strb()), 32'(StAccBR));
    step();
    check("conf_idle", 32'(strb()), 32'(StIdle));
    check("conf_cnt_dual", 32'(cnt_dual), 32'd0);
    check("conf_cnt_pairs", 32'(cnt_pairs), 32'd1);

    // Same-address read dual-issues.
    clear_counters();
    offer(4'h6, 4'h6, 1'b0);
    step();
    req_valid = 1'b0;
    check("same_rd_load", 32'(strb()), 32'(StLoadAb));
    step();
    check("same_rd_access", 32'(strb()), 32'(StAccAbR));
    step();
    check("same_rd_cnt_dual", 32'(cnt_dual), 32'd1);

    // Same-address write is serialised.
    offer(4'h6, 4'h6, 1'b1);
    step();
    req_valid = 1'b0;
    check("same_wr_load_a", 32'(strb()), 32'(StLoadA));
    step();
    check("same_wr_ld_a", 32'(strb()), 32'(StAccALdW));
    step();
    check("same_wr_ld_b", 32'(strb()), 32'(StAccBW));
    step();
    check("same_wr_cnt_dual", 32'(cnt_dual), 32'd1);

    // Back-to-back non-conflicting stream: 2 cycles per pair.
    clear_counters();
    for (int i = 0; i < 32; i++) begin
      offer(4'(i), 4'(i + 1), 1'b0);
      step();
      check("s1_load", 32'(strb()), 32'(StLoadAb));
      step();
      check("s1_access", 32'(strb()), 32'(StAccAbR));
    end
    req_valid = 1'b0;
    step();
    check("s1_cnt_pairs", 32'(cnt_pairs), 32'd32);
    check("s1_cnt_dual", 32'(cnt_dual), 32'd32);
    check("s1_cnt_cycles", 32'(cnt_cycles), 32'd65);

    // Back-to-back conflicting stream: 3 cycles per pair.
    clear_counters();
    for (int i = 0; i < 32; i++) begin
      offer(4'(i), 4'(i + 2), 1'b0);
      step();
      check("s2_load_a", 32'(strb()), 32'(StLoadA));
      step();
      step();
      check("s2_acc_b", 32'(strb()), 32'(StAccBR));
    end
    req_valid = 1'b0;
    step();
    check("s2_cnt_pairs", 32'(cnt_pairs), 32'd32);
    check("s2_cnt_dual", 32'(cnt_dual), 32'd0);
    check("s2_cnt_cycles", 32'(cnt_cycles), 32'd97);

    // Asynchronous reset while in S_ACC_A_LD_B.
    offer(4'h3, 4'h5, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    check("pre_rst_state", 32'(strb()), 32'(StAccALdR));
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_strobes", 32'(strb()), 32'(StIdle));
    check("rst_async_mar", 32'({mar_in_a, mar_in_b}), 32'd0);
    check("rst_async_cnt", {cnt_cycles, cnt_pairs}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_1", 32'(strb()), 32'(StIdle));
    step();
    check("post_rst_2", 32'(strb()), 32'(StIdle));
    check("post_rst_cycles", 32'(cnt_cycles), 32'd2);

    // Clear pulse.
    step();
    step();
    cnt_clear = 1'b1;
    step();
    check("clear_cycles", 32'(cnt_cycles), 32'd0);
    check("clear_pairs_dual", {cnt_pairs, cnt_dual}, 32'd0);
    cnt_clear = 1'b0;
    step();
    check("clear_then_count", 32'(cnt_cycles), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
